aes_core_arbiter: RTL and testbench

Shares one multicycle aes_128 encryption core between two independent requesters (e.g. TX and RX crypto paths). Each requester has a valid/ready request channel (plaintext + key) and a valid/ready response channel (ciphertext). The arbiter applies round-robin grant at each core input-sampling edge and tracks the single in-flight operation. It routes the core result into a per-requester response holding register and exposes busy/completion status.

---
 rtl/aes_core_arbiter.sv | 165 ++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one multicycle AES-128 core between two requesters.
// Tracks the single in-flight op and steers its result into the owner's response slot.

module aes_core_arbiter_slot #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fill,
  input  logic             i_drain,
  input  logic [127:0]     i_data,
  output logic             o_valid,
  output logic [127:0]     o_data,
  output logic [CNT_W-1:0] o_cnt
);
  logic             r_valid;
  logic [127:0]     r_data;
  logic [CNT_W-1:0] r_cnt;

  // Fill and drain never coincide: an occupied slot blocks its requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
endmodule

module aes_core_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_data,
  input  logic [127:0]     req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_data,
  input  logic [127:0]     req1_key,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [127:0]     rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [127:0]     rsp1_data,
  output logic [127:0]     core_in_bus,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out_bus,
  input  logic             core_ready,
  input  logic             core_valid,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_last_grant;

  logic [NREQ-1:0]             w_req_valid, w_rsp_ready, w_rsp_valid;
  logic [NREQ-1:0]             w_own_vec, w_elig, w_grant, w_fill, w_drain;
  logic [NREQ-1:0][127:0]      w_req_data, w_req_key, w_rsp_data;
  logic [NREQ-1:0][CNT_W-1:0]  w_cnt;
  logic                        w_inflight, w_accept, w_acc_id, w_complete;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};
  assign w_req_data  = {req1_data, req0_data};
  assign w_req_key   = {req1_key, req0_key};

  assign w_inflight = (r_state != ST_IDLE);
  // One-hot owner of the in-flight op; all-zero when idle.
  assign w_own_vec  = (r_state == ST_OWN1) ? 2'b10 :
                      (r_state == ST_OWN0) ? 2'b01 : 2'b00;

  // A requester with a pending or undelivered result waits, so its slot is free on completion.
  assign w_elig = w_req_valid & ~w_rsp_valid & ~w_own_vec;

  always_comb begin
    w_grant = '0;
    if (core_ready) begin
      if (&w_elig) w_grant = r_last_grant ? 2'b01 : 2'b10;
      else         w_grant = w_elig;
    end
  end

  assign w_accept   = |w_grant;
  assign w_acc_id   = w_grant[1];
  assign w_complete = core_valid && w_inflight;

  // Idle samples feed zeros; their results are dropped because nothing is in flight.
  always_comb begin
    core_in_bus = '0;
    core_key    = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (w_grant[n]) begin
        core_in_bus = w_req_data[n];
        core_key    = w_req_key[n];
      end
    end
  end

  // A new accept on the completion edge keeps the core busy under the new owner.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)        w_state_nxt = w_acc_id ? ST_OWN1 : ST_OWN0;
    else if (w_complete) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_last_grant <= w_acc_id;
    end
  end

  // Completion always goes to the owner registered before this edge.
  assign w_fill  = {NREQ{core_valid}} & w_own_vec;
  assign w_drain = w_rsp_valid & w_rsp_ready;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    aes_core_arbiter_slot #(.CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_fill  (w_fill[g]),
      .i_drain (w_drain[g]),
      .i_data  (core_out_bus),
      .o_valid (w_rsp_valid[g]),
      .o_data  (w_rsp_data[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_data  = w_rsp_data[0];
  assign rsp1_data  = w_rsp_data[1];
  assign done_cnt0  = w_cnt[0];
  assign done_cnt1  = w_cnt[1];
  assign busy       = w_inflight;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: a stand-in AES core with a fixed sample period,
// a scoreboard of expected ciphertexts, and a narrow-counter twin for wrap checks.

module tb_aes_core_arbiter;
  localparam int P = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [127:0] rsp0_data, rsp1_data, core_in_bus, core_key;
  logic [15:0] done_cnt0, done_cnt1;
  logic n_req0_ready, n_req1_ready, n_rsp0_valid, n_rsp1_valid, n_busy;
  logic [127:0] n_rsp0_data, n_rsp1_data, n_core_in_bus, n_core_key;
  logic [1:0] n_done_cnt0, n_done_cnt1;

  int n_chk = 0, n_err = 0;

  // Stand-in core: pt/key pairs other than FIPS-197 map through a simple reversible mix.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a;
  endfunction

  int m_phase = 0;
  logic m_have = 1'b0;
  logic [127:0] m_res = '0;
  logic core_ready, core_valid;
  logic [127:0] core_out_bus;
  assign core_ready   = (m_phase == P - 1);
  assign core_valid   = core_ready && m_have;
  assign core_out_bus = m_res;

  always @(posedge clk) begin
    m_phase <= (m_phase == P - 1) ? 0 : m_phase + 1;
    if (core_ready) begin
      m_res  <= aes_ref(core_in_bus, core_key);
      m_have <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  aes_core_arbiter #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .core_in_bus(core_in_bus), .core_key(core_key), .core_out_bus(core_out_bus),
    .core_ready(core_ready), .core_valid(core_valid), .busy(busy),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  aes_core_arbiter #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(n_req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(n_req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp0_valid(n_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(n_rsp0_data),
    .rsp1_valid(n_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(n_rsp1_data),
    .core_in_bus(n_core_in_bus), .core_key(n_core_key), .core_out_bus(core_out_bus),
    .core_ready(core_ready), .core_valid(core_valid), .busy(n_busy),
    .done_cnt0(n_done_cnt0), .done_cnt1(n_done_cnt1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled mid-low-phase, after stimulus settles, before the next posedge.
  logic [127:0] expq0[$], expq1[$];
  int grant_log[$];
  int acc_cnt[2] = '{0, 0};
  bit rsp0_seen = 0, rsp1_seen = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      expq0.delete();
      expq1.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        expq0.push_back(aes_ref(req0_data, req0_key)); grant_log.push_back(0); acc_cnt[0]++;
      end
      if (req1_valid && req1_ready) begin
        expq1.push_back(aes_ref(req1_data, req1_key)); grant_log.push_back(1); acc_cnt[1]++;
      end
      if (rsp0_valid && rsp0_ready) begin
        if (expq0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else chk("rsp0_data", rsp0_data, expq0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (expq1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else chk("rsp1_data", rsp1_data, expq1.pop_front());
      end
    end
    if (rsp0_valid) rsp0_seen = 1;
    if (rsp1_valid) rsp1_seen = 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Present one block and hold it until accepted; returns on the negedge after acceptance.
  task automatic send(input int id, input logic [127:0] d, input logic [127:0] k, input string tag);
    bit ok = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
    else         begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = (id == 0) ? req0_ready : req1_ready;
      @(negedge clk);
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk(tag, ok, 1);
  endtask

  task automatic wait_rsp(input int id, input string tag);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if ((id == 0 && rsp0_valid) || (id == 1 && rsp1_valid)) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    bit p0, p1, stable, clean, got;
    int n0, n1, a0, a1;
    logic [15:0] c0, c1;

    // Reset state
    cyc(2);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_done_cnt0", done_cnt0, 0);
    chk("rst_done_cnt1", done_cnt1, 0);

    // Both requesters streaming: grants alternate starting with requester 0
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 128'h0123456789abcdef_fedcba9876543210; req0_key = 128'h1111;
    req1_valid = 1'b1; req1_data = 128'hdeadbeef_00000000_cafef00d_00000000; req1_key = 128'h2222;
    n0 = 0; n1 = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 400 && (n0 < 4 || n1 < 4); c++) begin
      if (p0) begin n0++; req0_data = req0_data ^ 128'(n0 << 8); if (n0 == 4) req0_valid = 1'b0; end
      if (p1) begin n1++; req1_data = req1_data ^ 128'(n1 << 4); if (n1 == 4) req1_valid = 1'b0; end
      #1;
      p0 = req0_valid && req0_ready;
      p1 = req1_valid && req1_ready;
      @(negedge clk);
    end
    cyc(3 * P);
    chk("t2_grant_count", grant_log.size(), 8);
    if (grant_log.size() >= 8)
      for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
    chk("t2_done_cnt0", done_cnt0, 4);
    chk("t2_done_cnt1", done_cnt1, 4);
    chk("t2_w2_done_cnt0_wrap", n_done_cnt0, 0);
    chk("t2_q0_empty", expq0.size(), 0);
    chk("t2_q1_empty", expq1.size(), 0);

    // FIPS-197 on requester 0, response held until consumed
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1; rsp1_seen = 0;
    send(0, FIPS_PT, FIPS_KEY, "t1_accept");
    wait_rsp(0, "t1_rsp_arrives");
    chk("t1_fips_ct", rsp0_data, FIPS_CT);
    chk("t1_done_cnt0", done_cnt0, 1);
    chk("t1_busy_idle", busy, 0);
    cyc(5);
    chk("t1_held_valid", rsp0_valid, 1);
    chk("t1_held_data", rsp0_data, FIPS_CT);
    chk("t1_rsp1_never", rsp1_seen, 0);
    rsp0_ready = 1'b1;
    cyc(1);
    chk("t1_drained", rsp0_valid, 0);

    // Stalled response 0 blocks requester 0 while requester 1 keeps going
    rsp0_ready = 1'b0;
    send(0, 128'h00000000_11111111_22222222_33333333, 128'h44, "t3_accept_a");
    req0_valid = 1'b1; req0_data = 128'hbbbb_0000_bbbb_0000; req0_key = 128'h55;
    req1_valid = 1'b1; req1_data = 128'hcccc_1234_cccc_5678; req1_key = 128'h66;
    wait_rsp(0, "t3_rsp_a");
    chk("t3_rsp_a_data", rsp0_data,
        aes_ref(128'h00000000_11111111_22222222_33333333, 128'h44));
    held = rsp0_data; a0 = acc_cnt[0]; a1 = acc_cnt[1]; stable = 1;
    for (int i = 0; i < 30; i++) begin
      if (!rsp0_valid || rsp0_data !== held) stable = 0;
      @(negedge clk);
    end
    chk("t3_rsp0_stable", stable, 1);
    chk("t3_req0_blocked", acc_cnt[0] - a0, 0);
    chk("t3_req1_progress", (acc_cnt[1] - a1) >= 3, 1);
    rsp0_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acc_cnt[0] > a0) begin got = 1; break; end
    end
    req0_valid = 1'b0;
    chk("t3_req0_released", got, 1);
    req1_valid = 1'b0;
    cyc(4 * P);
    chk("t3_q0_empty", expq0.size(), 0);
    chk("t3_q1_empty", expq1.size(), 0);

    // Idle with core running: nothing moves, core sees zeros
    c0 = done_cnt0; c1 = done_cnt1; clean = 1;
    for (int i = 0; i < 50; i++) begin
      if (core_in_bus != 0 || core_key != 0 || rsp0_valid || rsp1_valid || busy) clean = 0;
      @(negedge clk);
    end
    chk("t4_idle_clean", clean, 1);
    chk("t4_cnt0_same", done_cnt0, c0);
    chk("t4_cnt1_same", done_cnt1, c1);

    // Reset while requester 1 op in flight: result discarded
    send(1, 128'h9999_8888_7777_6666, 128'h77, "t5_accept");
    chk("t5_busy_inflight", busy, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rsp1_seen = 0;
    chk("t5_busy_cleared", busy, 0);
    cyc(3 * P);
    chk("t5_rsp1_never", rsp1_seen, 0);
    chk("t5_done_cnt1", done_cnt1, 0);
    send(0, FIPS_PT, FIPS_KEY, "t5_fips_accept");
    wait_rsp(0, "t5_fips_rsp");
    chk("t5_fips_ct", rsp0_data, FIPS_CT);
    chk("t5_done_cnt0", done_cnt0, 1);

    // Counter wrap: 2-bit twin rolls over after the fourth completion
    for (int i = 1; i < 4; i++) begin
      send(0, 128'(32'h1000 + i), 128'h88, $sformatf("t6_accept%0d", i));
      wait_rsp(0, $sformatf("t6_rsp%0d", i));
    end
    cyc(2);
    chk("t6_done_cnt0", done_cnt0, 4);
    chk("t6_w2_wrap", n_done_cnt0, 0);
    chk("t6_w2_busy", n_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
